// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable FIFO family.
package fifo_pkg;

  // Read-port presentation mode.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Width needed to count 0..size inclusive.
  function automatic int unsigned fifo_lvl_w(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping pointer counting 0..SIZE-1, advancing on inc.
//   clk, rst_n : clock, async active-low reset
//   inc        : advance by one (wraps SIZE-1 -> 0)
//   ptr        : current pointer value
module fifo_wrap_ptr #(
  parameter int unsigned SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inc,
  output logic [$clog2(SIZE)-1:0]   ptr
);

  localparam int unsigned PW = $clog2(SIZE);

  // Explicit wrap compare so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(SIZE - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO, any depth >= 2, standard or FWFT read, programmable
// almost-full/almost-empty, exact level, sticky overflow/underflow.
//   clk, rst_n                : clock, async active-low reset
//   wr_en, wr_data            : write request and data
//   wr_full, wr_almost_full   : level == SIZE, level >= AF_THRESH
//   rd_en, rd_data            : read/pop request and data
//   rd_empty, rd_almost_empty : level == 0, level <= AE_THRESH
//   level                     : exact entry count
//   err_clr                   : clears overflow/underflow
//   overflow, underflow       : sticky error flags
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned BITS      = 32,
  parameter int unsigned SIZE      = 16,
  parameter int          FWFT      = 0,
  parameter int          AF_THRESH = 12,
  parameter int          AE_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [BITS-1:0]               wr_data,
  output logic                          wr_full,
  output logic                          wr_almost_full,
  input  logic                          rd_en,
  output logic [BITS-1:0]               rd_data,
  output logic                          rd_empty,
  output logic                          rd_almost_empty,
  output logic [fifo_lvl_w(SIZE)-1:0]   level,
  input  logic                          err_clr,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned LW   = fifo_lvl_w(SIZE);
  localparam int unsigned PW   = $clog2(SIZE);
  localparam fifo_mode_e  MODE = (FWFT == 1) ? FIFO_FWFT : FIFO_STD;
  localparam logic [LW-1:0] FULL_L = LW'(SIZE);
  localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);

  // Elaboration-time parameter guard.
  if (SIZE < 2) begin : g_bad_size
    $error("sync_fifo_prog: SIZE must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > int'(SIZE)) begin : g_bad_af
    $error("sync_fifo_prog: AF_THRESH must be in 1..SIZE");
  end
  if (AE_THRESH < 0 || AE_THRESH > int'(SIZE) - 1) begin : g_bad_ae
    $error("sync_fifo_prog: AE_THRESH must be in 0..SIZE-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_prog: FWFT must be 0 or 1");
  end

  logic [BITS-1:0] mem [SIZE];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            wr_acc;
  logic            rd_acc;

  // Flags decode only from the registered level.
  assign wr_full         = (level == FULL_L);
  assign rd_empty        = (level == '0);
  assign wr_almost_full  = (level >= AF_L);
  assign rd_almost_empty = (level <= AE_L);

  assign wr_acc = wr_en & ~wr_full;
  assign rd_acc = rd_en & ~rd_empty;

  fifo_wrap_ptr #(.SIZE(SIZE)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.SIZE(SIZE)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // Storage: single write port, no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Level tracks accepted traffic; accept rules keep it within 0..SIZE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      level <= level + LW'(wr_acc) - LW'(rd_acc);
    end
  end

  // Sticky errors; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & wr_full)  | (overflow  & ~err_clr);
      underflow <= (rd_en & rd_empty) | (underflow & ~err_clr);
    end
  end

  // Read data presentation.
  if (MODE == FIFO_FWFT) begin : g_fwft
    assign rd_data = mem[rd_ptr];
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data <= '0;
      end else if (rd_acc) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: three configurations (16-deep std, 5-deep std, 16-deep FWFT).
module tb_sync_fifo_prog;

  logic clk;
  logic rst_n;

  // Instance A: SIZE=16, FWFT=0, AF=12, AE=2
  logic        wr_en_a, rd_en_a, err_clr_a;
  logic [31:0] wr_data_a, rd_data_a;
  logic        wr_full_a, waf_a, rd_empty_a, rae_a, ovf_a, unf_a;
  logic [4:0]  level_a;

  // Instance B: SIZE=5, FWFT=0, AF=4, AE=1, BITS=8
  logic        wr_en_b, rd_en_b, err_clr_b;
  logic [7:0]  wr_data_b, rd_data_b;
  logic        wr_full_b, waf_b, rd_empty_b, rae_b, ovf_b, unf_b;
  logic [2:0]  level_b;

  // Instance C: SIZE=16, FWFT=1
  logic        wr_en_c, rd_en_c, err_clr_c;
  logic [31:0] wr_data_c, rd_data_c;
  logic        wr_full_c, waf_c, rd_empty_c, rae_c, ovf_c, unf_c;
  logic [4:0]  level_c;

  int n_chk  = 0;
  int n_pass = 0;

  sync_fifo_prog #(.BITS(32), .SIZE(16), .FWFT(0), .AF_THRESH(12), .AE_THRESH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .wr_full(wr_full_a), .wr_almost_full(waf_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
    .rd_empty(rd_empty_a), .rd_almost_empty(rae_a), .level(level_a),
    .err_clr(err_clr_a), .overflow(ovf_a), .underflow(unf_a)
  );

  sync_fifo_prog #(.BITS(8), .SIZE(5), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .wr_full(wr_full_b), .wr_almost_full(waf_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
    .rd_empty(rd_empty_b), .rd_almost_empty(rae_b), .level(level_b),
    .err_clr(err_clr_b), .overflow(ovf_b), .underflow(unf_b)
  );

  sync_fifo_prog #(.BITS(32), .SIZE(16), .FWFT(1), .AF_THRESH(12), .AE_THRESH(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_c), .wr_data(wr_data_c),
    .wr_full(wr_full_c), .wr_almost_full(waf_c), .rd_en(rd_en_c), .rd_data(rd_data_c),
    .rd_empty(rd_empty_c), .rd_almost_empty(rae_c), .level(level_c),
    .err_clr(err_clr_c), .overflow(ovf_c), .underflow(unf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en_a = 0; rd_en_a = 0; err_clr_a = 0; wr_data_a = '0;
    wr_en_b = 0; rd_en_b = 0; err_clr_b = 0; wr_data_b = '0;
    wr_en_c = 0; rd_en_c = 0; err_clr_c = 0; wr_data_c = '0;
    #12;
    // Reset state
    check("rst_empty", 32'(rd_empty_a), 32'd1);
    check("rst_full",  32'(wr_full_a),  32'd0);
    check("rst_af",    32'(waf_a),      32'd0);
    check("rst_ae",    32'(rae_a),      32'd1);
    check("rst_level", 32'(level_a),    32'd0);
    check("rst_data",  rd_data_a,       32'd0);
    check("rst_ovf",   32'(ovf_a),      32'd0);
    check("rst_unf",   32'(unf_a),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1/3: fill 0..15 with threshold tracking
    for (int i = 0; i < 16; i++) begin
      wr_en_a = 1; wr_data_a = 32'(i);
      tick();
      check("fill_level", 32'(level_a), 32'(i + 1));
      check("fill_af",    32'(waf_a),   32'((i + 1) >= 12));
      check("fill_ae",    32'(rae_a),   32'((i + 1) <= 2));
    end
    wr_en_a = 0;
    check("fill_full", 32'(wr_full_a), 32'd1);

    // 1/3: drain, data one cycle after rd_en
    for (int i = 0; i < 16; i++) begin
      rd_en_a = 1;
      tick();
      check("drain_data",  rd_data_a,       32'(i));
      check("drain_level", 32'(level_a),    32'(15 - i));
      check("drain_af",    32'(waf_a),      32'((15 - i) >= 12));
      check("drain_ae",    32'(rae_a),      32'((15 - i) <= 2));
    end
    rd_en_a = 0;
    check("drain_empty", 32'(rd_empty_a), 32'd1);
    check("drain_hold",  rd_data_a,       32'd15);

    // 5: full + simultaneous wr/rd -> write dropped
    for (int i = 0; i < 16; i++) begin
      wr_en_a = 1; wr_data_a = 32'(100 + i);
      tick();
    end
    wr_en_a = 1; rd_en_a = 1; wr_data_a = 32'h99;
    tick();
    wr_en_a = 0;
    check("full_wr_rd_level", 32'(level_a), 32'd15);
    check("full_wr_rd_ovf",   32'(ovf_a),   32'd1);
    check("full_wr_rd_data",  rd_data_a,    32'd100);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("after_ovf_data", rd_data_a, 32'(100 + i));
    end
    check("after_ovf_empty", 32'(rd_empty_a), 32'd1);
    // rd_en still high while empty -> underflow, data held
    tick();
    rd_en_a = 0;
    check("unf_set",  32'(unf_a), 32'd1);
    check("unf_hold", rd_data_a,  32'd115);
    check("unf_lvl",  32'(level_a), 32'd0);
    // clear together with a fresh underflow: set wins
    err_clr_a = 1; rd_en_a = 1;
    tick();
    rd_en_a = 0;
    check("clr_set_wins_unf", 32'(unf_a), 32'd1);
    check("clr_ovf",          32'(ovf_a), 32'd0);
    tick();
    err_clr_a = 0;
    check("clr_unf", 32'(unf_a), 32'd0);
    check("clr_ovf2", 32'(ovf_a), 32'd0);

    // 2: SIZE=5, three rounds of write 5 / read 5
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        wr_en_b = 1; wr_data_b = 8'(r * 10 + i);
        tick();
      end
      check("b_full",  32'(wr_full_b), 32'd1);
      check("b_level", 32'(level_b),   32'd5);
      wr_data_b = 8'hEE;   // rejected extra write
      tick();
      wr_en_b = 0;
      check("b_level_cap", 32'(level_b), 32'd5);
      check("b_ovf",       32'(ovf_b),   32'd1);
      for (int i = 0; i < 5; i++) begin
        rd_en_b = 1;
        tick();
        check("b_data", 32'(rd_data_b), 32'(r * 10 + i));
      end
      rd_en_b = 0;
      check("b_empty", 32'(rd_empty_b), 32'd1);
    end

    // 4: FWFT
    wr_en_c = 1; wr_data_c = 32'hA5;
    tick();
    wr_en_c = 0;
    check("fwft_data",  rd_data_c,        32'hA5);
    check("fwft_empty", 32'(rd_empty_c),  32'd0);
    rd_en_c = 1;
    tick();
    rd_en_c = 0;
    check("fwft_pop_empty", 32'(rd_empty_c), 32'd1);
    check("fwft_pop_level", 32'(level_c),    32'd0);
    wr_en_c = 1; wr_data_c = 32'h11;
    tick();
    wr_data_c = 32'h22;
    tick();
    wr_en_c = 0;
    check("fwft_head1", rd_data_c, 32'h11);
    rd_en_c = 1;
    tick();
    rd_en_c = 0;
    check("fwft_head2", rd_data_c,       32'h22);
    check("fwft_lvl1",  32'(level_c),    32'd1);

    // 6: async reset at level 7, no clock edge
    for (int i = 0; i < 7; i++) begin
      wr_en_a = 1; wr_data_a = 32'(200 + i);
      tick();
    end
    wr_en_a = 0;
    check("pre_rst_level", 32'(level_a), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_empty", 32'(rd_empty_a), 32'd1);
    check("async_rst_level", 32'(level_a),    32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    wr_en_a = 1; wr_data_a = 32'h77;
    tick();
    wr_en_a = 0; rd_en_a = 1;
    tick();
    rd_en_a = 0;
    check("post_rst_data",  rd_data_a,       32'h77);
    check("post_rst_empty", 32'(rd_empty_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
